// File: rtl/zorro2_cycle_sync.sv
`timescale 1ns/1ps
// zorro2_cycle_sync
// Front end between the asynchronous Zorro II bus pins and the z2 core arbiter.
// It synchronizes AS/UDS/LDS/READ into z_sample_clk and decodes the board window.
// Each bus cycle becomes one single-word req/ack transaction. For reads it also
// drives the returned word onto the bus under zDOE until AS is released.
// Optional build macro: ZORRO_TIMEOUT_EN adds a watchdog. The watchdog counts
// clocks in WAIT_DS and in REQ. When it reaches TIMEOUT_CYC it abandons the
// cycle and pulses timeout for one clock.
module zorro2_cycle_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW_BITS = 21,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        z_sample_clk,
  input  logic        reset_n,
  input  logic        znAS,
  input  logic        znUDS,
  input  logic        znLDS,
  input  logic        zREAD,
  input  logic [22:0] zA,
  input  logic [15:0] zD_in,
  input  logic        configured,
  input  logic [2:0]  base_addr,
  output logic [15:0] zD_out,
  output logic        zDOE,
  output logic        req,
  output logic        req_write,
  output logic [21:0] req_addr,
  output logic [15:0] req_data,
  output logic [1:0]  req_be,
  input  logic        ack,
  input  logic [15:0] rdata,
  output logic        timeout
);

  // zA[i] carries bus address bit A[i+1]. The window offset keeps A[WINDOW_BITS-1:1].
  localparam logic [21:0] ADDR_MASK = 22'((64'd1 << WINDOW_BITS) - 64'd1);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("zorro2_cycle_sync: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IGNORE,
    ST_WAIT_DS,
    ST_REQ,
    ST_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
  logic [SYNC_STAGES-1:0] uds_sync_q, uds_sync_d;
  logic [SYNC_STAGES-1:0] lds_sync_q, lds_sync_d;
  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic                   as_prev_q, as_prev_d;
  logic [20:0]            addr_q, addr_d;
  logic                   rd_q, rd_d;
  logic                   rel_q, rel_d;
  logic                   req_q, req_d;
  logic                   req_write_q, req_write_d;
  logic [21:0]            req_addr_q, req_addr_d;
  logic [15:0]            req_data_q, req_data_d;
  logic [1:0]             req_be_q, req_be_d;
  logic [15:0]            zd_out_q, zd_out_d;
  logic                   zdoe_q, zdoe_d;

  logic as_s, uds_s, lds_s, ds_s, rd_s;

`ifdef ZORRO_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_hit;
`endif

  assign as_s  = as_sync_q[SYNC_STAGES-1];
  assign uds_s = uds_sync_q[SYNC_STAGES-1];
  assign lds_s = lds_sync_q[SYNC_STAGES-1];
  assign rd_s  = rd_sync_q[SYNC_STAGES-1];
  // A data strobe is active when either byte lane strobe is low.
  assign ds_s  = uds_s & lds_s;

  // Shift the raw bus pins into the synchronizer chains. Each pin enters at bit 0.
  always_comb begin
    as_sync_d  = {as_sync_q[SYNC_STAGES-2:0], znAS};
    uds_sync_d = {uds_sync_q[SYNC_STAGES-2:0], znUDS};
    lds_sync_d = {lds_sync_q[SYNC_STAGES-2:0], znLDS};
    rd_sync_d  = {rd_sync_q[SYNC_STAGES-2:0], zREAD};
    as_prev_d  = as_s;
  end

  // Bus-cycle sequencer: next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    rel_d       = rel_q;
    req_d       = req_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_be_d    = req_be_q;
    zd_out_d    = zd_out_q;
    zdoe_d      = zdoe_q;
`ifdef ZORRO_TIMEOUT_EN
    cnt_d   = cnt_q + CNT_W'(1);
    tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef ZORRO_TIMEOUT_EN
        cnt_d = '0;
`endif
        // Start a new bus cycle on the falling edge of the synchronized AS.
        if (as_prev_q && !as_s) begin
          addr_d  = zA[20:0];
          rd_d    = rd_s;
          rel_d   = 1'b0;
          state_d = (configured && (zA[22:20] == base_addr)) ? ST_WAIT_DS : ST_IGNORE;
        end
      end
      ST_IGNORE: begin
        if (as_s) state_d = ST_IDLE;
      end
      ST_WAIT_DS: begin
        if (as_s) begin
          state_d = ST_IDLE;
        end else if (!ds_s) begin
          req_be_d    = {~uds_s, ~lds_s};
          req_data_d  = zD_in;
          req_write_d = ~rd_q;
          req_addr_d  = {addr_q, 1'b0} & ADDR_MASK;
          req_d       = 1'b1;
          state_d     = ST_REQ;
`ifdef ZORRO_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
`ifdef ZORRO_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_d   = 1'b1;
          state_d = ST_IGNORE;
        end
`endif
      end
      ST_REQ: begin
        // The master can release AS before ack arrives. The request still
        // completes, but the data is never driven onto the bus.
        if (as_s) rel_d = 1'b1;
        if (ack) begin
          req_d = 1'b0;
          if (rel_q || as_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
            if (rd_q) begin
              zd_out_d = rdata;
              zdoe_d   = 1'b1;
            end
          end
        end
`ifdef ZORRO_TIMEOUT_EN
        else if (tmo_hit) begin
          req_d   = 1'b0;
          zdoe_d  = 1'b0;
          tmo_d   = 1'b1;
          state_d = ST_IGNORE;
        end
`endif
      end
      ST_HOLD: begin
        if (as_s) begin
          zdoe_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers. Reset presets the strobe chains to inactive.
  always_ff @(posedge z_sample_clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      as_sync_q   <= '1;
      uds_sync_q  <= '1;
      lds_sync_q  <= '1;
      rd_sync_q   <= '1;
      as_prev_q   <= 1'b1;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      rel_q       <= 1'b0;
      req_q       <= 1'b0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_be_q    <= '0;
      zd_out_q    <= '0;
      zdoe_q      <= 1'b0;
`ifdef ZORRO_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      as_sync_q   <= as_sync_d;
      uds_sync_q  <= uds_sync_d;
      lds_sync_q  <= lds_sync_d;
      rd_sync_q   <= rd_sync_d;
      as_prev_q   <= as_prev_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      rel_q       <= rel_d;
      req_q       <= req_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_be_q    <= req_be_d;
      zd_out_q    <= zd_out_d;
      zdoe_q      <= zdoe_d;
`ifdef ZORRO_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req       = req_q;
  assign req_write = req_write_q;
  assign req_addr  = req_addr_q;
  assign req_data  = req_data_q;
  assign req_be    = req_be_q;
  assign zD_out    = zd_out_q;
  assign zDOE      = zdoe_q;
`ifdef ZORRO_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_zorro2_cycle_sync.sv
`timescale 1ns/1ps
// Self-checking bench for zorro2_cycle_sync. The reference model works per bus
// cycle. It predicts hit or miss, the request fields and the bus data from the
// address and strobe rules. Timing is checked against the stated latencies.
module tb_zorro2_cycle_sync;
  localparam int S  = 2;
  localparam int WB = 21;
`ifdef ZORRO_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        znAS, znUDS, znLDS, zREAD;
  logic [22:0] zA;
  logic [15:0] zD_in;
  logic        configured;
  logic [2:0]  base_addr;
  logic [15:0] zD_out;
  logic        zDOE, req, req_write;
  logic [21:0] req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_be;
  logic        ack;
  logic [15:0] rdata;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  zorro2_cycle_sync #(
    .SYNC_STAGES(S),
    .WINDOW_BITS(WB),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .z_sample_clk(clk),
    .reset_n(reset_n),
    .znAS(znAS),
    .znUDS(znUDS),
    .znLDS(znLDS),
    .zREAD(zREAD),
    .zA(zA),
    .zD_in(zD_in),
    .configured(configured),
    .base_addr(base_addr),
    .zD_out(zD_out),
    .zDOE(zDOE),
    .req(req),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_be(req_be),
    .ack(ack),
    .rdata(rdata),
    .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    znAS  = 1'b1;
    znUDS = 1'b1;
    znLDS = 1'b1;
  endtask

  // One complete bus cycle. AS and the data strobes fall together. All checks
  // are made against the per-cycle prediction.
  task automatic do_cycle(input string nm, input logic rd, input logic [22:0] a,
                          input logic [1:0] be, input logic [15:0] wd, input logic cfg,
                          input logic [2:0] base, input int ack_dly,
                          input logic [15:0] rdat, input logic early);
    logic        hit;
    logic [21:0] exp_addr;
    logic [41:0] got, exp, snap;
    bit          bad;
    hit      = cfg && ((int'(a) >> 20) == int'(base));
    exp_addr = 22'((int'(a) * 2) % (1 << WB));
    exp      = {1'b1, ~rd, be, exp_addr, wd};
    configured = cfg; base_addr = base; zA = a; zREAD = rd; zD_in = wd;
    znAS = 1'b0; znUDS = ~be[1]; znLDS = ~be[0];
    bad = 0;
    repeat (S + 1) begin
      tick();
      if (req !== 1'b0 || zDOE !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL %s_early_req: req=%b zDOE=%b expected 0 before latency", nm, req, zDOE);
    tick();
    if (!hit) begin
      bad = 0;
      repeat (6) begin
        if (req !== 1'b0 || zDOE !== 1'b0) bad = 1;
        tick();
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s_miss: req=%b zDOE=%b expected 0 for whole cycle", nm, req, zDOE);
      end
      release_bus();
      repeat (S + 2) tick();
      return;
    end
    if (bad) errors++;
    got = {req, req_write, req_be, req_addr, req_data};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_fields: got %h expected %h", nm, got, exp);
    end
    snap = got;
    if (early) release_bus();
    bad = 0;
    repeat (ack_dly) begin
      tick();
      if ({req, req_write, req_be, req_addr, req_data} !== snap || zDOE !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_req_stable: got %h expected %h", nm, {req, req_write, req_be, req_addr, req_data}, snap);
    end
    ack = 1'b1; rdata = rdat;
    tick();
    ack = 1'b0; rdata = 16'($urandom);
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL %s_req_drop: req=%b expected 0", nm, req);
    end
    checks++;
    if (rd && !early) begin
      if (zDOE !== 1'b1 || zD_out !== rdat) begin
        errors++;
        $display("FAIL %s_rdata: zDOE=%b zD_out=%h expected 1 %h", nm, zDOE, zD_out, rdat);
      end
    end else if (zDOE !== 1'b0) begin
      errors++;
      $display("FAIL %s_doe_off: zDOE=%b expected 0", nm, zDOE);
    end
    if (early) begin
      bad = 0;
      repeat (S + 2) begin
        tick();
        if (zDOE !== 1'b0 || req !== 1'b0) bad = 1;
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s_early_rel: zDOE=%b req=%b expected 0 0", nm, zDOE, req);
      end
      return;
    end
    bad = 0;
    repeat (2) begin
      tick();
      if (zDOE !== (rd ? 1'b1 : 1'b0) || req !== 1'b0 || (rd && zD_out !== rdat)) bad = 1;
    end
    release_bus();
    repeat (S) begin
      tick();
      if (zDOE !== (rd ? 1'b1 : 1'b0)) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s_hold: zDOE=%b zD_out=%h expected %b %h", nm, zDOE, zD_out, rd, rdat);
    end
    tick();
    checks++;
    if (zDOE !== 1'b0) begin
      errors++;
      $display("FAIL %s_doe_release: zDOE=%b expected 0", nm, zDOE);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ack = 1'b0; rdata = '0;
    configured = 1'b1; base_addr = 3'd3; zA = 23'h300008; zD_in = 16'($urandom);
    repeat (2) begin
      znAS = 1'($urandom); znUDS = 1'($urandom); znLDS = 1'($urandom); zREAD = 1'($urandom);
      tick();
    end
    checks++;
    if ({zD_out, zDOE, req, req_write, req_addr, req_data, req_be, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {zD_out, zDOE, req, req_write, req_addr, req_data, req_be, timeout});
    end
    release_bus();
    reset_n = 1'b1;
    repeat (S + 2) tick();
  endtask

  task automatic test_read_hit();
    do_cycle("read_hit", 1'b1, 23'h300008, 2'b11, 16'h5555, 1'b1, 3'd3, 5, 16'hBEEF, 1'b0);
  endtask

  task automatic test_write_byte();
    do_cycle("write_byte", 1'b0, 23'h300080, 2'b01, 16'h12AB, 1'b1, 3'd3, 2, 16'h0000, 1'b0);
  endtask

  task automatic test_miss();
    do_cycle("miss_base", 1'b1, 23'h740000, 2'b11, 16'h0000, 1'b1, 3'd3, 0, 16'h1111, 1'b0);
    do_cycle("unconfigured", 1'b1, 23'h300008, 2'b11, 16'h0000, 1'b0, 3'd3, 0, 16'h2222, 1'b0);
  endtask

  task automatic test_early_release();
    do_cycle("early_rel", 1'b1, 23'h300010, 2'b11, 16'h0000, 1'b1, 3'd3, 3, 16'hCAFE, 1'b1);
    do_cycle("after_early", 1'b1, 23'h300012, 2'b10, 16'h0000, 1'b1, 3'd3, 1, 16'hF00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_cycle("b2b_a", 1'b0, 23'h100004, 2'b10, 16'hA5A5, 1'b1, 3'd1, 0, 16'h0, 1'b0);
    do_cycle("b2b_b", 1'b1, 23'h1FFFFF, 2'b11, 16'h0000, 1'b1, 3'd1, 0, 16'h7E57, 1'b0);
  endtask

  task automatic test_ack_outside();
    ack = 1'b1; rdata = 16'hDEAD;
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (zDOE !== 1'b0 || req !== 1'b0) begin
      errors++;
      $display("FAIL ack_idle: zDOE=%b req=%b expected 0 0", zDOE, req);
    end
  endtask

  task automatic test_mid_reset();
    configured = 1'b1; base_addr = 3'd2; zA = 23'h200040; zREAD = 1'b1;
    znAS = 1'b0; znUDS = 1'b0; znLDS = 1'b0;
    repeat (S + 2) tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (req !== 1'b0 || zDOE !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: req=%b zDOE=%b expected 0 0", req, zDOE);
    end
    release_bus();
    reset_n = 1'b1;
    repeat (S + 2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [2:0]  base;
      logic [22:0] a;
      logic        early, cfg;
      int          dly;
      base  = 3'($urandom);
      a     = 23'($urandom);
      if ($urandom_range(0, 3) != 0) a[22:20] = base;
      cfg   = ($urandom_range(0, 7) != 0);
      early = ($urandom_range(0, 3) == 0);
      dly   = early ? int'($urandom_range(S, S + 3)) : int'($urandom_range(0, 6));
      do_cycle($sformatf("rand%0d", i), 1'($urandom), a, 2'($urandom_range(1, 3)),
               16'($urandom), cfg, base, dly, 16'($urandom), early);
    end
  endtask

`ifdef ZORRO_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    configured = 1'b1; base_addr = 3'd3; zA = 23'h300020; zREAD = 1'b1;
    znAS = 1'b0; znUDS = 1'b0; znLDS = 1'b0;
    repeat (S + 2) tick();
    n = 0;
    while (timeout !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    checks++;
    if (n != TMO || req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: after %0d clocks req=%b expected %0d clocks req=0", n, req, TMO);
    end
    tick();
    ack = 1'b1; rdata = 16'h9999;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width: timeout=%b expected 0", timeout);
    end
    tick();
    ack = 1'b0;
    tick();
    checks++;
    if (zDOE !== 1'b0 || req !== 1'b0) begin
      errors++;
      $display("FAIL late_ack: zDOE=%b req=%b expected 0 0", zDOE, req);
    end
    release_bus();
    repeat (S + 2) tick();
  endtask
`else
  task automatic test_no_timeout();
    do_cycle("long_wait", 1'b1, 23'h300100, 2'b11, 16'h0, 1'b1, 3'd3, 300, 16'h4242, 1'b0);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tied: timeout=%b expected 0", timeout);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; ack = 1'b0; rdata = '0;
    release_bus();
    zREAD = 1'b1; zA = '0; zD_in = '0; configured = 1'b0; base_addr = '0;
    test_reset();
    test_read_hit();
    test_write_byte();
    test_miss();
    test_early_release();
    test_back_to_back();
    test_ack_outside();
    test_mid_reset();
    test_random();
`ifdef ZORRO_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
